tia_pf_serializer: RTL and testbench



---
 rtl/tia_pf_serializer_if.sv | 23 ++
 rtl/tia_pf_serializer.sv | 100 ++++++++++
 tb/tb_tia_pf_serializer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/tia_pf_serializer_if.sv
// rtl/tia_pf_serializer_if.sv - playfield serializer tick, start, register-write and pixel signals
interface tia_pf_serializer_if;
  logic       hclk_en;
  logic       cnt;
  logic       rhb;
  logic       ref_bar;
  logic [7:0] d;
  logic       pf0;
  logic       pf1;
  logic       pf2;
  logic       cntd;
  logic       pf;

  modport master (
    output hclk_en, cnt, rhb, ref_bar, d, pf0, pf1, pf2,
    input  cntd, pf
  );

  modport slave (
    input  hclk_en, cnt, rhb, ref_bar, d, pf0, pf1, pf2,
    output cntd, pf
  );
endinterface

// File: rtl/tia_pf_serializer.sv
// rtl/tia_pf_serializer.sv - TIA playfield serializer; TIA_PF_REFLECT_EN enables mirrored right half
module tia_pf_serializer (
  input logic             clkp,
  input logic             reset_bar,
  tia_pf_serializer_if.slave bus
);

  logic [3:0]  pf0_q;
  logic [7:0]  pf1_q;
  logic [7:0]  pf2_q;
  logic [19:0] scan_vec;
  logic [4:0]  pos_q, pos_d;
  logic        active_q, active_d;
  logic        fwd_start;
  logic        sel_bit;
  logic        pf_stage_q;
  logic        pf_q;
  logic        cntd_q;

`ifdef TIA_PF_REFLECT_EN
  logic        rev_q, rev_d;
  logic        rev_start;
  assign fwd_start = bus.rhb | (bus.cnt & bus.ref_bar);
  assign rev_start = bus.cnt & ~bus.ref_bar;
`else
  assign fwd_start = bus.rhb | bus.cnt;
`endif

  // Bit p of scan_vec is forward scan position p; PF1 is scanned MSB first.
  always_comb begin
    scan_vec = '0;
    scan_vec[3:0]   = pf0_q;
    scan_vec[19:12] = pf2_q;
    for (int i = 0; i < 8; i++) begin
      scan_vec[4 + i] = pf1_q[7 - i];
    end
  end

  always_comb begin
    pos_d    = pos_q;
    active_d = active_q;
`ifdef TIA_PF_REFLECT_EN
    rev_d    = rev_q;
`endif
    if (fwd_start) begin
      pos_d    = 5'd0;
      active_d = 1'b1;
`ifdef TIA_PF_REFLECT_EN
      rev_d    = 1'b0;
    end else if (rev_start) begin
      pos_d    = 5'd19;
      active_d = 1'b1;
      rev_d    = 1'b1;
    end else if (active_q && rev_q) begin
      if (pos_q == 5'd0) active_d = 1'b0;
      else               pos_d    = pos_q - 5'd1;
`endif
    end else if (active_q) begin
      if (pos_q == 5'd19) active_d = 1'b0;
      else                pos_d    = pos_q + 5'd1;
    end
  end

  // The tick reads the position it lands on, so a start shows its bit immediately.
  assign sel_bit = active_d & scan_vec[pos_d];

  always_ff @(posedge clkp) begin
    if (!reset_bar) begin
      pf0_q      <= '0;
      pf1_q      <= '0;
      pf2_q      <= '0;
      pos_q      <= '0;
      active_q   <= 1'b0;
`ifdef TIA_PF_REFLECT_EN
      rev_q      <= 1'b0;
`endif
      pf_stage_q <= 1'b0;
      pf_q       <= 1'b0;
      cntd_q     <= 1'b0;
    end else begin
      if (bus.pf0) pf0_q <= bus.d[7:4];
      if (bus.pf1) pf1_q <= bus.d;
      if (bus.pf2) pf2_q <= bus.d;
      if (bus.hclk_en) begin
        pos_q      <= pos_d;
        active_q   <= active_d;
`ifdef TIA_PF_REFLECT_EN
        rev_q      <= rev_d;
`endif
        pf_stage_q <= sel_bit;
        cntd_q     <= bus.cnt;
      end
      pf_q <= pf_stage_q;
    end
  end

  assign bus.pf   = pf_q;
  assign bus.cntd = cntd_q;

endmodule

// File: tb/tb_tia_pf_serializer.sv
// tb/tb_tia_pf_serializer.sv - directed bench for tia_pf_serializer
module tb_tia_pf_serializer;

  logic clkp;
  logic reset_bar;
  int   checks;
  int   failures;
  logic pf_s;
  logic cntd_s;
  logic [41:0] expv;

  tia_pf_serializer_if bus ();

  tia_pf_serializer dut (
    .clkp      (clkp),
    .reset_bar (reset_bar),
    .bus       (bus)
  );

  initial clkp = 1'b0;
  always #5 clkp = ~clkp;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // One tick period of 4 clkp; pf/cntd sampled after the edge following the tick.
  task automatic tick(input logic r, input logic c);
    @(negedge clkp);
    bus.hclk_en = 1'b1;
    bus.rhb     = r;
    bus.cnt     = c;
    @(negedge clkp);
    bus.hclk_en = 1'b0;
    bus.rhb     = 1'b0;
    bus.cnt     = 1'b0;
    @(negedge clkp);
    pf_s   = bus.pf;
    cntd_s = bus.cntd;
    @(negedge clkp);
  endtask

  task automatic wr(input int sel, input logic [7:0] val);
    @(negedge clkp);
    bus.d   = val;
    bus.pf0 = (sel == 0);
    bus.pf1 = (sel == 1);
    bus.pf2 = (sel == 2);
    @(negedge clkp);
    bus.pf0 = 1'b0;
    bus.pf1 = 1'b0;
    bus.pf2 = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_bar   = 1'b0;
    bus.hclk_en = 1'b0;
    bus.rhb     = 1'b0;
    bus.cnt     = 1'b0;
    bus.ref_bar = 1'b1;
    bus.d       = 8'h00;
    bus.pf0     = 1'b0;
    bus.pf1     = 1'b0;
    bus.pf2     = 1'b0;
    repeat (3) @(negedge clkp);
    chk("reset_pf", bus.pf, 1'b0);
    chk("reset_cntd", bus.cntd, 1'b0);
    reset_bar = 1'b1;

    // No starts: everything stays low.
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("idle_pf_%0d", i), pf_s, 1'b0);
      chk($sformatf("idle_cntd_%0d", i), cntd_s, 1'b0);
    end

    // Only PF0.4 set; low nibble of d must be ignored.
    wr(0, 8'h1F);
    wr(1, 8'h00);
    wr(2, 8'h00);
    for (int i = 0; i < 23; i++) begin
      tick(i == 0, 1'b0);
      chk($sformatf("pf0bit_%0d", i), pf_s, (i == 0));
    end

    // Repeat: positions 11 and 19 in both halves.
    wr(0, 8'h00);
    wr(1, 8'h01);
    wr(2, 8'h80);
    bus.ref_bar = 1'b1;
    expv = '0;
    expv[11] = 1'b1; expv[19] = 1'b1; expv[31] = 1'b1; expv[39] = 1'b1;
    for (int i = 0; i < 42; i++) begin
      tick(i == 0, i == 20);
      chk($sformatf("repeat_%0d", i), pf_s, expv[i]);
      if (i == 20) chk("cntd_set", cntd_s, 1'b1);
      if (i == 21) chk("cntd_clr", cntd_s, 1'b0);
    end

    // ref_bar = 0: mirrored right half when reflection is built in.
    bus.ref_bar = 1'b0;
    expv = '0;
    expv[11] = 1'b1; expv[19] = 1'b1;
`ifdef TIA_PF_REFLECT_EN
    expv[20] = 1'b1; expv[28] = 1'b1;
`else
    expv[31] = 1'b1; expv[39] = 1'b1;
`endif
    for (int i = 0; i < 42; i++) begin
      tick(i == 0, i == 20);
      chk($sformatf("reflect_%0d", i), pf_s, expv[i]);
    end

    // rhb and cnt together with ref_bar = 0: forward start wins.
    wr(0, 8'h10);
    expv = '0;
    expv[0] = 1'b1; expv[11] = 1'b1; expv[19] = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick(i == 0, i == 0);
      chk($sformatf("both_%0d", i), pf_s, expv[i]);
    end

    // Mid-scan PF2 write, then reset during the scan.
    bus.ref_bar = 1'b1;
    wr(0, 8'h00);
    wr(1, 8'h00);
    wr(2, 8'h00);
    for (int i = 0; i < 15; i++) begin
      tick(i == 0, 1'b0);
      chk($sformatf("midwr_%0d", i), pf_s, 1'b0);
    end
    wr(2, 8'hFF);
    for (int i = 15; i < 18; i++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("midwr_%0d", i), pf_s, 1'b1);
    end
    @(negedge clkp);
    reset_bar = 1'b0;
    @(negedge clkp);
    reset_bar = 1'b1;
    chk("rst_mid_pf", bus.pf, 1'b0);
    wr(0, 8'h10);
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("post_rst_idle_%0d", i), pf_s, 1'b0);
    end
    tick(1'b1, 1'b0);
    chk("post_rst_start", pf_s, 1'b1);
    tick(1'b0, 1'b0);
    chk("post_rst_pos1", pf_s, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
